// File: rtl/mul_pkg.sv
// Shared constants, FSM encoding and tag payload for the multiplier consumer.
package mul_pkg;

    localparam int unsigned MUL_LAT = 5;
    localparam int unsigned OP_W    = 16;
    localparam int unsigned PROD_W  = 32;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic v;
        logic last;
    } tag_t;

endpackage

// File: rtl/mul_tag_pipe.sv
// Delay line carrying the {v, last} sideband alongside the multiplier pipeline.
module mul_tag_pipe
    import mul_pkg::*;
#(
    parameter int unsigned DEPTH = 5
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [DEPTH];

    // Shift tags one stage per cycle; reset clears every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/mul_dot_accum.sv
// Feeds a fixed-latency multiplier and accumulates its products into one
// dot-product per vector, handed off over a valid/ready result port.
module mul_dot_accum
    import mul_pkg::*;
#(
    parameter int unsigned MUL_LAT = mul_pkg::MUL_LAT,
    parameter int unsigned ACC_W   = 48,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic              in_last,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic [PROD_W-1:0] mul_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam int unsigned SUM_W = ACC_W + 1;

    state_t             state;
    state_t             state_next;
    tag_t               tag_in;
    tag_t               tag_out;
    logic               accept;
    logic               fin;
    logic [ACC_W-1:0]   acc;
    logic               ovf;
    logic [CNT_W-1:0]   cnt;
    logic [SUM_W-1:0]   acc_sum;

    assign in_ready = (state == ACCUM);
    assign accept   = in_valid && in_ready;

    // Operands reach the multiplier only for accepted beats.
    assign mul_a = accept ? in_a : '0;
    assign mul_b = accept ? in_b : '0;

    assign tag_in.v    = accept;
    assign tag_in.last = accept && in_last;

    mul_tag_pipe #(
        .DEPTH (MUL_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Extra top bit captures the carry out of the accumulator.
    assign acc_sum = {1'b0, acc} + SUM_W'(mul_p);
    assign fin     = (state == DRAIN) && tag_out.v && tag_out.last;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            ACCUM:   if (accept && in_last) state_next = DRAIN;
            DRAIN:   if (fin)               state_next = HOLD;
            HOLD:    if (out_ready)         state_next = ACCUM;
            default:                        state_next = ACCUM;
        endcase
    end

    // Accumulator, beat counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (accept && (cnt != '1)) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (fin) begin
                out_sum   <= acc_sum[ACC_W-1:0];
                out_count <= cnt;
                out_ovf   <= ovf | acc_sum[ACC_W];
                out_valid <= 1'b1;
                acc       <= '0;
                ovf       <= 1'b0;
                cnt       <= '0;
            end else if (tag_out.v) begin
                acc <= acc_sum[ACC_W-1:0];
                ovf <= ovf | acc_sum[ACC_W];
            end
            if ((state == HOLD) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mul_dot_accum.sv
// Directed bench for mul_dot_accum with a behavioural 5-cycle multiplier.
module tb_mul_dot_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_last;
    logic        out_ready;

    logic        in_ready;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [31:0] mul_p;
    logic        out_valid;
    logic [47:0] out_sum;
    logic [15:0] out_count;
    logic        out_ovf;

    logic        in_ready_n;
    logic [15:0] mul_a_n;
    logic [15:0] mul_b_n;
    logic [31:0] mul_p_n;
    logic        out_valid_n;
    logic [32:0] out_sum_n;
    logic [15:0] out_count_n;
    logic        out_ovf_n;

    logic [31:0] pipe   [5];
    logic [31:0] pipe_n [5];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural pipelined multipliers, one per DUT, no reset.
    always @(posedge clk) begin
        pipe[0]   <= 32'(mul_a) * 32'(mul_b);
        pipe_n[0] <= 32'(mul_a_n) * 32'(mul_b_n);
        for (int k = 1; k < 5; k++) begin
            pipe[k]   <= pipe[k-1];
            pipe_n[k] <= pipe_n[k-1];
        end
    end
    assign mul_p   = pipe[4];
    assign mul_p_n = pipe_n[4];

    mul_dot_accum #(.MUL_LAT(5), .ACC_W(48), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
    );

    mul_dot_accum #(.MUL_LAT(5), .ACC_W(33), .CNT_W(16)) dut33 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_a(mul_a_n), .mul_b(mul_b_n), .mul_p(mul_p_n),
        .out_valid(out_valid_n), .out_ready(out_ready),
        .out_sum(out_sum_n), .out_count(out_count_n), .out_ovf(out_ovf_n)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Present one beat, wait for in_ready, and report the acceptance cycle.
    task automatic send_beat(input logic [15:0] a, input logic [15:0] b,
                             input logic last, output int t_acc);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        #1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("beat_ready", 64'(in_ready), 64'd1);
        check_eq("beat_mul_a", 64'(mul_a), 64'(a));
        t_acc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result(output int t_out);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("out_valid_seen", 64'(out_valid), 64'd1);
        t_out = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_last;
        int t_out;
        int t_tmp;
        int gap;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset state
        check_eq("rst_in_ready",  64'(in_ready),  64'd1);
        check_eq("rst_mul_a",     64'(mul_a),     64'd0);
        check_eq("rst_mul_b",     64'(mul_b),     64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_sum",   64'(out_sum),   64'd0);
        check_eq("rst_out_count", 64'(out_count), 64'd0);
        check_eq("rst_out_ovf",   64'(out_ovf),   64'd0);

        // 1: basic 3-beat vector, latency t_last+6
        send_beat(16'd1, 16'd4, 1'b0, t_tmp);
        send_beat(16'd2, 16'd5, 1'b0, t_tmp);
        send_beat(16'd3, 16'd6, 1'b1, t_last);
        check_eq("t1_busy", 64'(in_ready), 64'd0);
        wait_result(t_out);
        check_eq("t1_latency", 64'(t_out - t_last), 64'd6);
        check_eq("t1_sum",   64'(out_sum),   64'd32);
        check_eq("t1_count", 64'(out_count), 64'd3);
        check_eq("t1_ovf",   64'(out_ovf),   64'd0);
        @(posedge clk); #1;
        check_eq("t1_valid_drop", 64'(out_valid), 64'd0);
        check_eq("t1_ready_back", 64'(in_ready),  64'd1);

        // 2: single-beat max product
        send_beat(16'hFFFF, 16'hFFFF, 1'b1, t_last);
        wait_result(t_out);
        check_eq("t2_latency", 64'(t_out - t_last), 64'd6);
        check_eq("t2_sum",   64'(out_sum),   64'hFFFE0001);
        check_eq("t2_count", 64'(out_count), 64'd1);
        @(posedge clk); #1;

        // 3: back-pressure on the result port
        out_ready = 1'b0;
        send_beat(16'd1, 16'd4, 1'b0, t_tmp);
        send_beat(16'd2, 16'd5, 1'b0, t_tmp);
        send_beat(16'd3, 16'd6, 1'b1, t_last);
        wait_result(t_out);
        in_valid = 1'b1; in_a = 16'd50; in_b = 16'd50;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("t3_hold_valid", 64'(out_valid), 64'd1);
            check_eq("t3_hold_sum",   64'(out_sum),   64'd32);
            check_eq("t3_hold_count", 64'(out_count), 64'd3);
            check_eq("t3_hold_ready", 64'(in_ready),  64'd0);
            check_eq("t3_hold_mul_a", 64'(mul_a),     64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("t3_ready_back", 64'(in_ready),  64'd1);
        check_eq("t3_valid_drop", 64'(out_valid), 64'd0);

        // 4: 33-bit accumulator, no carry then carry
        send_beat(16'hFFFF, 16'hFFFF, 1'b0, t_tmp);
        send_beat(16'hFFFF, 16'hFFFF, 1'b1, t_last);
        wait_result(t_out);
        check_eq("t4a_sum33", 64'(out_sum_n), 64'h1FFFC0002);
        check_eq("t4a_ovf33", 64'(out_ovf_n), 64'd0);
        @(posedge clk); #1;
        send_beat(16'hFFFF, 16'hFFFF, 1'b0, t_tmp);
        send_beat(16'hFFFF, 16'hFFFF, 1'b0, t_tmp);
        send_beat(16'hFFFF, 16'hFFFF, 1'b1, t_last);
        wait_result(t_out);
        check_eq("t4b_sum33",   64'(out_sum_n),   64'h0FFFA0003);
        check_eq("t4b_ovf33",   64'(out_ovf_n),   64'd1);
        check_eq("t4b_count33", 64'(out_count_n), 64'd3);
        check_eq("t4b_sum48",   64'(out_sum),     64'h2FFFA0003);
        check_eq("t4b_ovf48",   64'(out_ovf),     64'd0);
        @(posedge clk); #1;
        send_beat(16'd2, 16'd2, 1'b1, t_last);
        wait_result(t_out);
        check_eq("t4c_ovf33_clear", 64'(out_ovf_n), 64'd0);
        check_eq("t4c_sum33",       64'(out_sum_n), 64'd4);
        @(posedge clk); #1;

        // 5: reset in cycle 3 of a 4-beat vector
        send_beat(16'd5, 16'd5, 1'b0, t_tmp);
        send_beat(16'd6, 16'd6, 1'b0, t_tmp);
        in_valid = 1'b1; in_a = 16'd8; in_b = 16'd8; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        #1;
        check_eq("t5_rst_ready", 64'(in_ready),  64'd1);
        check_eq("t5_rst_valid", 64'(out_valid), 64'd0);
        send_beat(16'd7, 16'd3, 1'b1, t_last);
        wait_result(t_out);
        check_eq("t5_latency", 64'(t_out - t_last), 64'd6);
        check_eq("t5_sum",   64'(out_sum),   64'd21);
        check_eq("t5_count", 64'(out_count), 64'd1);
        @(posedge clk); #1;

        // 6: gapped 8-beat vector, operands gated in gaps
        for (int i = 1; i <= 8; i++) begin
            send_beat(16'(i), 16'(i), (i == 8), t_last);
            if (i < 8) begin
                gap = i % 4;
                in_valid = 1'b0; in_a = 16'h0055; in_b = 16'h0055;
                for (int g = 0; g < gap; g++) begin
                    #1;
                    check_eq("t6_gap_mul_a", 64'(mul_a), 64'd0);
                    check_eq("t6_gap_mul_b", 64'(mul_b), 64'd0);
                    @(posedge clk); #1;
                end
            end
        end
        wait_result(t_out);
        check_eq("t6_latency", 64'(t_out - t_last), 64'd6);
        check_eq("t6_sum",   64'(out_sum),   64'd204);
        check_eq("t6_count", 64'(out_count), 64'd8);
        check_eq("t6_ovf",   64'(out_ovf),   64'd0);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
